// File: rtl/sseg_pkg.sv
// Shared types and constants for the seven-segment scan scheduler.
package sseg_pkg;

    typedef enum logic [1:0] {
        OWN_A  = 2'd0,
        PEND_B = 2'd1,
        OWN_B  = 2'd2
    } own_state_t;

    localparam logic [6:0] SEG_OFF    = 7'h7F;
    localparam logic [3:0] AN_OFF     = 4'b1111;
    localparam int         NUM_DIGITS = 4;

    function automatic int cnt_width(input int div);
        return (div > 1) ? $clog2(div) : 1;
    endfunction

endpackage

// File: rtl/scan_prescaler.sv
// Digit-slot prescaler: cnt runs 0..SCAN_DIV-1 and tick marks the last count of a slot.
module scan_prescaler
    import sseg_pkg::*;
#(
    parameter int SCAN_DIV = 100000,
    localparam int CNT_W   = cnt_width(SCAN_DIV)
) (
    input  logic             CLK,
    input  logic             RST,
    output logic [CNT_W-1:0] cnt,
    output logic             tick
);

    assign tick = (cnt == CNT_W'(SCAN_DIV - 1));

    always_ff @(posedge CLK) begin
        if (RST) begin
            cnt <= '0;
        end else if (tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/sseg_scan_sched.sv
// Four-digit display scan scheduler with frame-aligned A/B ownership arbitration.
// Optional SSEG_DIM_EN adds a brightness input that shortens the anode on-time per slot.
//
// state  | meaning
// OWN_A  | source A drives the display
// PEND_B | B requested, waiting for a frame boundary
// OWN_B  | source B drives the display for at least HOLD_FRAMES frames
module sseg_scan_sched
    import sseg_pkg::*;
#(
    parameter int SCAN_DIV    = 100000,
    parameter int HOLD_FRAMES = 60
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic [27:0] a_digits,
    input  logic        b_req,
    input  logic [27:0] b_digits,
`ifdef SSEG_DIM_EN
    input  logic [1:0]  brightness,
`endif
    output logic        b_gnt,
    output logic [3:0]  an,
    output logic [6:0]  sseg,
    output logic        frame_done
);

    localparam int CNT_W  = cnt_width(SCAN_DIV);
    localparam int HOLD_W = $clog2(HOLD_FRAMES + 1);

    logic [CNT_W-1:0]  cnt;
    logic              tick;
    logic [1:0]        idx;
    own_state_t        state;
    logic [HOLD_W-1:0] hold_cnt;
    logic [27:0]       src_digits;
    logic [6:0]        cur_digit;
    logic              an_on;

    scan_prescaler #(.SCAN_DIV(SCAN_DIV)) u_prescaler (
        .CLK  (CLK),
        .RST  (RST),
        .cnt  (cnt),
        .tick (tick)
    );

    assign src_digits = (state == OWN_B) ? b_digits : a_digits;

    always_comb begin
        cur_digit = src_digits[6:0];
        case (idx)
            2'd0: cur_digit = src_digits[6:0];
            2'd1: cur_digit = src_digits[13:7];
            2'd2: cur_digit = src_digits[20:14];
            2'd3: cur_digit = src_digits[27:21];
            default: cur_digit = src_digits[6:0];
        endcase
    end

`ifdef SSEG_DIM_EN
    // SCAN_DIV is a multiple of 4, so each brightness step is a quarter slot.
    logic [31:0] on_limit;
    assign on_limit = (32'(brightness) + 32'd1) * 32'(SCAN_DIV / 4);
    assign an_on    = (32'(cnt) < on_limit);
`else
    assign an_on    = 1'b1;
`endif

    always_ff @(posedge CLK) begin
        if (RST) begin
            idx        <= 2'd0;
            state      <= OWN_A;
            hold_cnt   <= '0;
            an         <= AN_OFF;
            sseg       <= SEG_OFF;
            b_gnt      <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            if (tick) begin
                idx <= idx + 2'd1;
            end
            frame_done <= tick && (idx == 2'd3);
            an         <= an_on ? ~(4'b0001 << idx) : AN_OFF;
            sseg       <= cur_digit;

            // frame_done here is the registered pulse, i.e. the boundary just passed
            case (state)
                OWN_A: begin
                    if (b_req) begin
                        state <= PEND_B;
                    end
                end
                PEND_B: begin
                    if (!b_req) begin
                        state <= OWN_A;
                    end else if (frame_done) begin
                        state    <= OWN_B;
                        b_gnt    <= 1'b1;
                        hold_cnt <= '0;
                    end
                end
                OWN_B: begin
                    if (frame_done) begin
                        if (!b_req && (hold_cnt >= HOLD_W'(HOLD_FRAMES))) begin
                            state <= OWN_A;
                            b_gnt <= 1'b0;
                        end else if (hold_cnt < HOLD_W'(HOLD_FRAMES)) begin
                            hold_cnt <= hold_cnt + HOLD_W'(1);
                        end
                    end
                end
                default: begin
                    state <= OWN_A;
                    b_gnt <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sseg_scan_sched.sv
// Scoreboard bench for sseg_scan_sched: a frame-level reference model queues expected outputs per clock.
module tb_sseg_scan_sched;

    localparam int D  = 4;
    localparam int H  = 2;
    localparam int FR = 4 * D;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic [27:0] a_digits = {7'h0F, 7'h12, 7'h4F, 7'h01};
    logic        b_req = 1'b0;
    logic [27:0] b_digits = {7'h30, 7'h24, 7'h19, 7'h40};
    logic        b_gnt;
    logic [3:0]  an;
    logic [6:0]  sseg;
    logic        frame_done;
`ifdef SSEG_DIM_EN
    logic [1:0]  brightness = 2'd3;
`endif

    sseg_scan_sched #(.SCAN_DIV(D), .HOLD_FRAMES(H)) dut (
        .CLK        (CLK),
        .RST        (RST),
        .a_digits   (a_digits),
        .b_req      (b_req),
        .b_digits   (b_digits),
`ifdef SSEG_DIM_EN
        .brightness (brightness),
`endif
        .b_gnt      (b_gnt),
        .an         (an),
        .sseg       (sseg),
        .frame_done (frame_done)
    );

    always #5 CLK = ~CLK;

    typedef struct packed {
        logic [3:0] an;
        logic [6:0] sseg;
        logic       gnt;
        logic       fd;
    } exp_t;

    exp_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;
    int   dut_rises = 0;
    int   model_rises = 0;

    // Reference model: time since reset in clocks, owner (0=A,1=pending,2=B), frames held.
    int   m_k    = 0;
    int   m_own  = 0;
    int   m_hold = 0;
    logic m_fd   = 1'b0;

    task automatic step(input logic rst_i, input logic req_i);
        exp_t e;
        logic [31:0] r;
        int cnt, idx, prev_own;
        logic [27:0] sel;
        @(negedge CLK);
        RST   = rst_i;
        b_req = req_i;
        if ($urandom_range(15) == 0) begin r = $urandom; a_digits = r[27:0]; end
        if ($urandom_range(15) == 0) begin r = $urandom; b_digits = r[27:0]; end
`ifdef SSEG_DIM_EN
        if ($urandom_range(31) == 0) brightness = 2'($urandom_range(3));
`endif
        if (rst_i) begin
            m_k = 0; m_own = 0; m_hold = 0; m_fd = 1'b0;
            e = '{an: 4'b1111, sseg: 7'h7F, gnt: 1'b0, fd: 1'b0};
        end else begin
            cnt = m_k % D;
            idx = (m_k / D) % 4;
            sel = (m_own == 2) ? b_digits : a_digits;
            e.an = 4'b1111;
            e.an[idx] = 1'b0;
`ifdef SSEG_DIM_EN
            if (cnt >= (int'(brightness) + 1) * D / 4) e.an = 4'b1111;
`endif
            e.sseg = sel[idx*7 +: 7];
            prev_own = m_own;
            if (m_own == 0) begin
                if (req_i) m_own = 1;
            end else if (m_own == 1) begin
                if (!req_i) m_own = 0;
                else if (m_fd) begin m_own = 2; m_hold = 0; end
            end else if (m_fd) begin
                if (!req_i && m_hold >= H) m_own = 0;
                else if (m_hold < H) m_hold++;
            end
            if (m_own == 2 && prev_own != 2) model_rises++;
            e.gnt = (m_own == 2);
            e.fd  = ((m_k % FR) == FR - 1);
            m_fd  = e.fd;
            m_k++;
        end
        exp_q.push_back(e);
    endtask

    logic prev_gnt = 1'b0;
    initial begin
        exp_t e;
        forever begin
            @(posedge CLK);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                checks++;
                if ({an, sseg, b_gnt, frame_done} !== e) begin
                    failures++;
                    $display("FAIL outputs t=%0t got an=%b sseg=%h gnt=%b fd=%b expected an=%b sseg=%h gnt=%b fd=%b",
                             $time, an, sseg, b_gnt, frame_done, e.an, e.sseg, e.gnt, e.fd);
                end
                if (b_gnt === 1'b1 && prev_gnt !== 1'b1) dut_rises++;
                prev_gnt = b_gnt;
            end
        end
    end

    initial begin
        logic req;
        repeat (3) step(1'b1, 1'b0);
        // free-running scan with A only
        repeat (3 * FR) step(1'b0, 1'b0);
        // request mid-frame, drop once granted, let the hold run out
        for (int i = 0; i < 64 && (m_k % FR) != 7; i++) step(1'b0, 1'b0);
        for (int i = 0; i < 200 && m_own != 2; i++) step(1'b0, 1'b1);
        step(1'b0, 1'b1);
        repeat (6 * FR) step(1'b0, 1'b0);
        // short request inside one frame never earns a grant
        for (int i = 0; i < 64 && (m_k % FR) != 2; i++) step(1'b0, 1'b0);
        repeat (3) step(1'b0, 1'b1);
        repeat (2 * FR) step(1'b0, 1'b0);
        // reset while B owns the display at digit 2
        for (int i = 0; i < 200 && m_own != 2; i++) step(1'b0, 1'b1);
        for (int i = 0; i < 200 && ((m_k / D) % 4) != 2; i++) step(1'b0, 1'b1);
        step(1'b1, 1'b1);
        repeat (2 * FR) step(1'b0, 1'b0);
        // randomized request traffic
        req = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(24) == 0) req = ~req;
            step($urandom_range(999) == 0, req);
        end
        repeat (3) @(negedge CLK);
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain got %0d pending expected 0", exp_q.size());
        end
        checks++;
        if (dut_rises != model_rises) begin
            failures++;
            $display("FAIL grant_count got %0d expected %0d", dut_rises, model_rises);
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
